// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared mode encodings and burst FSM state type for univ_shift_reg
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } usr_state_t;

endpackage

// File: rtl/usr_burst_ctrl.sv
// rtl/usr_burst_ctrl.sv - burst FSM and remaining-shift counter; decides load/shift/direction each edge
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rs_n,
    input  logic [1:0]    mode,
    input  logic          start,
    input  logic [CW-1:0] amount,
    output logic          shift_en,
    output logic          dir,
    output logic          load_en,
    output logic          busy,
    output logic          done
);

    usr_state_t    state_q, state_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          dir_q, dir_d;
    logic [CW-1:0] count;
    logic          is_shift_mode;

    assign count         = (amount > CW'(WIDTH)) ? CW'(WIDTH) : amount;
    assign is_shift_mode = (mode == MODE_SHR) || (mode == MODE_SHL);

    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        dir_d    = dir_q;
        shift_en = 1'b0;
        dir      = dir_q;
        load_en  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                dir = (mode == MODE_SHL);
                if (mode == MODE_LOAD) begin
                    load_en = 1'b1;
                end else if (is_shift_mode) begin
                    if (start) begin
                        dir_d = (mode == MODE_SHL);
                        if (count == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            // First burst shift happens on the start edge itself
                            shift_en = 1'b1;
                            busy     = 1'b1;
                            rem_d    = count - CW'(1);
                            state_d  = (count == CW'(1)) ? ST_DONE : ST_SHIFT;
                        end
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                rem_d    = rem_q - CW'(1);
                if (rem_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with load, hold and burst shift
// Optional USR_ROTATE_EN: shifts rotate and the serial inputs are ignored.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rs_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CW-1:0]    amount,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             shift_en, dir, load_en;
    logic             fill_r, fill_l;

    usr_burst_ctrl #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_ctrl (
        .clk      (clk),
        .rs_n     (rs_n),
        .mode     (mode),
        .start    (start),
        .amount   (amount),
        .shift_en (shift_en),
        .dir      (dir),
        .load_en  (load_en),
        .busy     (busy),
        .done     (done)
    );

`ifdef USR_ROTATE_EN
    assign fill_r = q_q[0];
    assign fill_l = q_q[WIDTH-1];
`else
    assign fill_r = sin_r;
    assign fill_l = sin_l;
`endif

    always_comb begin
        q_d = q_q;
        if (load_en) begin
            q_d = din;
        end else if (shift_en) begin
            q_d = dir ? {q_q[WIDTH-2:0], fill_l} : {fill_r, q_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q    = q_q;
    assign so_r = q_q[0];
    assign so_l = q_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg against a behavioural model
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rs_n;
    logic [1:0]    mode;
    logic [W-1:0]  din;
    logic          sin_r, sin_l, start;
    logic [CW-1:0] amount;
    logic [W-1:0]  q;
    logic          so_r, so_l, busy, done;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk    (clk),
        .rs_n   (rs_n),
        .mode   (mode),
        .din    (din),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .start  (start),
        .amount (amount),
        .q      (q),
        .so_r   (so_r),
        .so_l   (so_l),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Model: register value, bursts still owed, burst direction, done-cycle flag
    logic [W-1:0] m_q;
    int           m_left;
    logic         m_dir;
    logic         m_done;

    function automatic logic [W-1:0] do_shift(input logic [W-1:0] v, input logic left);
        logic [W-1:0] f;
        if (left) begin
`ifdef USR_ROTATE_EN
            f = W'(v >> (W - 1));
`else
            f = W'(sin_l);
`endif
            return W'(v << 1) | f;
        end else begin
`ifdef USR_ROTATE_EN
            f = W'(v & W'(1));
`else
            f = W'(sin_r);
`endif
            return (v >> 1) | W'(f << (W - 1));
        end
    endfunction

    function automatic int clamp_amt(input logic [CW-1:0] a);
        return (int'(a) > W) ? W : int'(a);
    endfunction

    logic [W-1:0] n_q;
    int           n_left;
    logic         n_dir, n_done;

    always @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            m_q    <= '0;
            m_left <= 0;
            m_dir  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            n_q    = m_q;
            n_left = m_left;
            n_dir  = m_dir;
            n_done = 1'b0;
            if (m_done) begin
                n_q = m_q;
            end else if (m_left > 0) begin
                n_q    = do_shift(m_q, m_dir);
                n_left = m_left - 1;
                n_done = (n_left == 0);
            end else if (mode == 2'b11) begin
                n_q = din;
            end else if (mode == 2'b01 || mode == 2'b10) begin
                n_dir = (mode == 2'b10);
                if (start) begin
                    if (clamp_amt(amount) == 0) begin
                        n_done = 1'b1;
                    end else begin
                        n_q    = do_shift(m_q, n_dir);
                        n_left = clamp_amt(amount) - 1;
                        n_done = (n_left == 0);
                    end
                end else begin
                    n_q = do_shift(m_q, n_dir);
                end
            end
            m_q    <= n_q;
            m_left <= n_left;
            m_dir  <= n_dir;
            m_done <= n_done;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic exp_busy;
    always_comb begin
        exp_busy = (m_left > 0) ||
                   ((m_left == 0) && !m_done && start && (mode == 2'b01 || mode == 2'b10) &&
                    (clamp_amt(amount) > 0));
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q",    32'(q),    32'(m_q));
            check("model_so_r", 32'(so_r), 32'(m_q & W'(1)));
            check("model_so_l", 32'(so_l), 32'(m_q >> (W - 1)));
            check("model_busy", 32'(busy), 32'(exp_busy));
            check("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic drive(input logic [1:0] m, input logic [W-1:0] d, input logic sr,
                         input logic sl, input logic st, input logic [CW-1:0] a);
        mode = m; din = d; sin_r = sr; sin_l = sl; start = st; amount = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rs_n = 1'b1; mode = 2'b00; din = '0; sin_r = 1'b0; sin_l = 1'b0;
        start = 1'b0; amount = '0;
        #3 rs_n = 1'b0;
        #1;
        check("reset_q", 32'(q), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rs_n = 1'b1;

        // Serial-in on the right shift path
        drive(2'b01, '0, 1'b1, 1'b0, 1'b0, '0);
        drive(2'b01, '0, 1'b0, 1'b0, 1'b0, '0);
        drive(2'b01, '0, 1'b1, 1'b0, 1'b0, '0);
        drive(2'b01, '0, 1'b1, 1'b0, 1'b0, '0);
        check("serial_in_q", 32'(q), 32'hD0);
        repeat (4) drive(2'b01, '0, 1'b0, 1'b0, 1'b0, '0);
        check("serial_out_q", 32'(q), 32'h0D);
        check("serial_out_first_bit", 32'(so_r), 32'h1);

        // Load then three left shifts
        drive(2'b11, 8'hA5, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) drive(2'b10, '0, 1'b0, 1'b0, 1'b0, '0);
        check("shl3_q", 32'(q), 32'h28);
        check("shl3_so_l", 32'(so_l), 32'h0);

        // Burst of three right shifts
        drive(2'b11, 8'h80, 1'b0, 1'b0, 1'b0, '0);
        mode = 2'b01; start = 1'b1; amount = CW'(3); sin_r = 1'b0;
        #1 check("burst_busy_c1", 32'(busy), 32'h1);
        @(posedge clk); #1;
        start = 1'b0; mode = 2'b00;
        check("burst_busy_c2", 32'(busy), 32'h1);
        check("burst_q_c2", 32'(q), 32'h40);
        @(posedge clk); #1;
        check("burst_busy_c3", 32'(busy), 32'h1);
        @(posedge clk); #1;
        check("burst_done_c4", 32'(done), 32'h1);
        check("burst_busy_c4", 32'(busy), 32'h0);
        check("burst_q_c4", 32'(q), 32'h10);
        @(posedge clk); #1;
        check("burst_done_c5", 32'(done), 32'h0);

        // Zero-length burst
        mode = 2'b01; start = 1'b1; amount = '0;
        #1 check("zero_busy", 32'(busy), 32'h0);
        @(posedge clk); #1;
        start = 1'b0; mode = 2'b00;
        check("zero_done", 32'(done), 32'h1);
        check("zero_q", 32'(q), 32'h10);

        // Clamped burst with load requests ignored while busy
        drive(2'b00, '0, 1'b0, 1'b0, 1'b0, '0);
        drive(2'b11, 8'h5A, 1'b0, 1'b0, 1'b0, '0);
        drive(2'b01, '0, 1'b1, 1'b0, 1'b1, CW'(15));
        for (int i = 0; i < 7; i++) begin
            check("clamp_busy", 32'(busy), 32'h1);
            drive(2'b11, 8'hAA, 1'b1, 1'b0, 1'b0, CW'(15));
        end
        check("clamp_done", 32'(done), 32'h1);
        check("clamp_q", 32'(q), 32'hFF);
        drive(2'b00, '0, 1'b0, 1'b0, 1'b0, '0);

        // Reset in the second burst cycle
        drive(2'b11, 8'hF0, 1'b0, 1'b0, 1'b0, '0);
        drive(2'b01, '0, 1'b0, 1'b0, 1'b1, CW'(5));
        mode = 2'b00; start = 1'b0;
        check("abort_busy_before", 32'(busy), 32'h1);
        #2 rs_n = 1'b0;
        #1;
        check("abort_q", 32'(q), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        @(posedge clk); #1 rs_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("abort_no_done", 32'(done), 32'h0);
            drive(2'b00, '0, 1'b0, 1'b0, 1'b0, '0);
        end

        // Right shift of 0x81: rotates or fills depending on build
        drive(2'b11, 8'h81, 1'b0, 1'b0, 1'b0, '0);
        drive(2'b01, '0, 1'b0, 1'b0, 1'b0, '0);
`ifdef USR_ROTATE_EN
        check("rotate_q", 32'(q), 32'hC0);
`else
        check("fill_q", 32'(q), 32'h40);
`endif

        // Randomised traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                start = 1'b0;
                #2 rs_n = 1'b0;
                @(posedge clk); #1 rs_n = 1'b1;
            end else begin
                drive(2'($urandom_range(0, 3)), W'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 7) == 0), CW'($urandom_range(0, 15)));
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
